// File: rtl/tc_pl_cap_gain_sched.sv
// Capture gain sequencer: arbitrates PS/PL gain requests and runs the controller handshake.
// Optional RUN-state timeout abort is built when TC_PL_CAP_GAIN_SCHED_TMO_EN is defined.
module tc_pl_cap_gain_sched #(
  parameter int CAP0_1 = 3,
  parameter int TMO_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [CAP0_1-2:0]  req0_gain,
  output logic               ack0,
  input  logic               req1,
  input  logic [CAP0_1-2:0]  req1_gain,
  output logic               ack1,
  output logic               ack_err,
  output logic [CAP0_1-2:0]  gain_value,
  output logic               gain_en,
  input  logic               gain_cmpt,
  input  logic [TMO_W-1:0]   cap_gain_tmo,
  output logic [CAP0_1-2:0]  cur_gain,
  output logic               cur_valid,
  output logic               busy,
  output logic               tmo_err
);

  localparam int GW = CAP0_1 - 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic          gid;
  logic [GW-1:0] gain_q;
  logic [GW-1:0] sel_gain;
  logic          skip;
  logic          tmo_hit;

  assign sel_gain = req0 ? req0_gain : req1_gain;
  assign skip     = cur_valid && (sel_gain == cur_gain);

`ifdef TC_PL_CAP_GAIN_SCHED_TMO_EN
  logic [TMO_W-1:0] cnt;

  assign tmo_hit = (cap_gain_tmo != '0) &&
                   (cnt == cap_gain_tmo - TMO_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      tmo_err <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      ack_err <= 1'b0;
      if (state == LOAD) begin
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + TMO_W'(1);
        if (!gain_cmpt && tmo_hit) begin
          tmo_err <= 1'b1;
          ack_err <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo = ^cap_gain_tmo;
  assign tmo_hit    = 1'b0;
  assign tmo_err    = 1'b0;
  assign ack_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gid        <= 1'b0;
      gain_q     <= '0;
      gain_value <= '0;
      gain_en    <= 1'b0;
      cur_gain   <= '0;
      cur_valid  <= 1'b0;
      busy       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gid    <= !req0;
            gain_q <= sel_gain;
            busy   <= 1'b1;
            if (skip) begin
              ack0  <= req0;
              ack1  <= !req0;
              state <= DONE;
            end else begin
              gain_value <= sel_gain;
              state      <= LOAD;
            end
          end
        end
        // gain_en held low one cycle so the controller's gain mux settles
        LOAD: begin
          gain_en <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          if (gain_cmpt) begin
            gain_en   <= 1'b0;
            cur_gain  <= gain_q;
            cur_valid <= 1'b1;
            ack0      <= !gid;
            ack1      <= gid;
            state     <= DONE;
          end else if (tmo_hit) begin
            gain_en   <= 1'b0;
            cur_valid <= 1'b0;
            ack0      <= !gid;
            ack1      <= gid;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_pl_cap_gain_sched.sv
// Directed bench for tc_pl_cap_gain_sched.
// Observed vector: {busy,gain_en,ack0,ack1,ack_err,tmo_err,cur_valid,cur_gain,gain_value}.
module tb_tc_pl_cap_gain_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0;
  logic [1:0]  req0_gain = 2'd0;
  logic        ack0;
  logic        req1 = 1'b0;
  logic [1:0]  req1_gain = 2'd0;
  logic        ack1;
  logic        ack_err;
  logic [1:0]  gain_value;
  logic        gain_en;
  logic        gain_cmpt = 1'b0;
  logic [31:0] cap_gain_tmo = 32'd0;
  logic [1:0]  cur_gain;
  logic        cur_valid;
  logic        busy;
  logic        tmo_err;
  logic [10:0] obs;

  int errors = 0;
  int checks = 0;

  tc_pl_cap_gain_sched #(.CAP0_1(3), .TMO_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req0_gain(req0_gain), .ack0(ack0),
    .req1(req1), .req1_gain(req1_gain), .ack1(ack1),
    .ack_err(ack_err), .gain_value(gain_value),
    .gain_en(gain_en), .gain_cmpt(gain_cmpt),
    .cap_gain_tmo(cap_gain_tmo), .cur_gain(cur_gain),
    .cur_valid(cur_valid), .busy(busy), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  assign obs = {busy, gain_en, ack0, ack1, ack_err, tmo_err,
                cur_valid, cur_gain, gain_value};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (obs !== 11'b0) begin
      errors++;
      $display("FAIL reset: got %b want %b", obs, 11'b0);
    end
  endtask

  task automatic test_single();
    req1 = 1'b1;
    req1_gain = 2'd2;
    step();
    checks++;
    if (obs !== 11'b1_0_0_0_0_0_0_00_10) begin
      errors++;
      $display("FAIL single_load: got %b want %b", obs, 11'b1_0_0_0_0_0_0_00_10);
    end
    step();
    checks++;
    if (obs !== 11'b1_1_0_0_0_0_0_00_10) begin
      errors++;
      $display("FAIL single_run: got %b want %b", obs, 11'b1_1_0_0_0_0_0_00_10);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (gain_en !== 1'b1) begin
      errors++;
      $display("FAIL single_hold: got gain_en=%b want 1", gain_en);
    end
    gain_cmpt = 1'b1;
    step();
    checks++;
    if (obs !== 11'b1_0_0_1_0_0_1_10_10) begin
      errors++;
      $display("FAIL single_done: got %b want %b", obs, 11'b1_0_0_1_0_0_1_10_10);
    end
    req1 = 1'b0;
    gain_cmpt = 1'b0;
    step();
    checks++;
    if (obs !== 11'b0_0_0_0_0_0_1_10_10) begin
      errors++;
      $display("FAIL single_idle: got %b want %b", obs, 11'b0_0_0_0_0_0_1_10_10);
    end
  endtask

  task automatic test_priority();
    int lows;
    req0 = 1'b1;
    req0_gain = 2'd1;
    req1 = 1'b1;
    req1_gain = 2'd3;
    step();
    checks++;
    if (obs !== 11'b1_0_0_0_0_0_1_10_01) begin
      errors++;
      $display("FAIL prio_load0: got %b want %b", obs, 11'b1_0_0_0_0_0_1_10_01);
    end
    step();
    gain_cmpt = 1'b1;
    step();
    checks++;
    if (obs !== 11'b1_0_1_0_0_0_1_01_01) begin
      errors++;
      $display("FAIL prio_ack0: got %b want %b", obs, 11'b1_0_1_0_0_0_1_01_01);
    end
    req0 = 1'b0;
    gain_cmpt = 1'b0;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      if (gain_en) break;
      lows++;
      step();
    end
    checks++;
    if (lows != 3) begin
      errors++;
      $display("FAIL prio_gap: got %0d low cycles want 3", lows);
    end
    checks++;
    if (obs !== 11'b1_1_0_0_0_0_1_01_11) begin
      errors++;
      $display("FAIL prio_run1: got %b want %b", obs, 11'b1_1_0_0_0_0_1_01_11);
    end
    gain_cmpt = 1'b1;
    step();
    checks++;
    if (obs !== 11'b1_0_0_1_0_0_1_11_11) begin
      errors++;
      $display("FAIL prio_ack1: got %b want %b", obs, 11'b1_0_0_1_0_0_1_11_11);
    end
    req1 = 1'b0;
    gain_cmpt = 1'b0;
    step();
  endtask

  task automatic test_skip();
    req0 = 1'b1;
    req0_gain = 2'd3;
    step();
    checks++;
    if (obs !== 11'b1_0_1_0_0_0_1_11_11) begin
      errors++;
      $display("FAIL skip_ack: got %b want %b", obs, 11'b1_0_1_0_0_0_1_11_11);
    end
    req0 = 1'b0;
    step();
    checks++;
    if (obs !== 11'b0_0_0_0_0_0_1_11_11) begin
      errors++;
      $display("FAIL skip_idle: got %b want %b", obs, 11'b0_0_0_0_0_0_1_11_11);
    end
  endtask

  task automatic test_gain_change();
    req1 = 1'b1;
    req1_gain = 2'd1;
    step();
    step();
    checks++;
    if (obs !== 11'b1_1_0_0_0_0_1_11_01) begin
      errors++;
      $display("FAIL chg_run: got %b want %b", obs, 11'b1_1_0_0_0_0_1_11_01);
    end
    req1_gain = 2'd2;
    step();
    step();
    gain_cmpt = 1'b1;
    step();
    checks++;
    if (obs !== 11'b1_0_0_1_0_0_1_01_01) begin
      errors++;
      $display("FAIL chg_done: got %b want %b", obs, 11'b1_0_0_1_0_0_1_01_01);
    end
    req1 = 1'b0;
    gain_cmpt = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1;
    req0_gain = 2'd2;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (obs !== 11'b0) begin
      errors++;
      $display("FAIL rstmid_clear: got %b want %b", obs, 11'b0);
    end
    rst = 1'b0;
    req0 = 1'b0;
    step();
    checks++;
    if (obs !== 11'b0) begin
      errors++;
      $display("FAIL rstmid_noack: got %b want %b", obs, 11'b0);
    end
    req1 = 1'b1;
    req1_gain = 2'd0;
    step();
    checks++;
    if (obs !== 11'b1_0_0_0_0_0_0_00_00) begin
      errors++;
      $display("FAIL rstmid_load: got %b want %b", obs, 11'b1_0_0_0_0_0_0_00_00);
    end
    step();
    gain_cmpt = 1'b1;
    step();
    checks++;
    if (obs !== 11'b1_0_0_1_0_0_1_00_00) begin
      errors++;
      $display("FAIL rstmid_done: got %b want %b", obs, 11'b1_0_0_1_0_0_1_00_00);
    end
    req1 = 1'b0;
    gain_cmpt = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int highs;
    cap_gain_tmo = 32'd10;
    req0 = 1'b1;
    req0_gain = 2'd2;
    step();
    step();
    highs = 0;
    while (gain_en && highs < 30) begin
      highs++;
      step();
    end
`ifdef TC_PL_CAP_GAIN_SCHED_TMO_EN
    checks++;
    if (highs != 10) begin
      errors++;
      $display("FAIL tmo_len: got %0d en cycles want 10", highs);
    end
    checks++;
    if (obs !== 11'b1_0_1_0_1_1_0_00_10) begin
      errors++;
      $display("FAIL tmo_ack: got %b want %b", obs, 11'b1_0_1_0_1_1_0_00_10);
    end
    req0 = 1'b0;
    step();
    step();
    checks++;
    if (obs !== 11'b0_0_0_0_0_1_0_00_10) begin
      errors++;
      $display("FAIL tmo_sticky: got %b want %b", obs, 11'b0_0_0_0_0_1_0_00_10);
    end
`else
    checks++;
    if (highs != 30) begin
      errors++;
      $display("FAIL notmo_len: got %0d en cycles want 30", highs);
    end
    checks++;
    if (obs !== 11'b1_1_0_0_0_0_1_00_10) begin
      errors++;
      $display("FAIL notmo_wait: got %b want %b", obs, 11'b1_1_0_0_0_0_1_00_10);
    end
    gain_cmpt = 1'b1;
    step();
    checks++;
    if (obs !== 11'b1_0_1_0_0_0_1_10_10) begin
      errors++;
      $display("FAIL notmo_done: got %b want %b", obs, 11'b1_0_1_0_0_0_1_10_10);
    end
    req0 = 1'b0;
    gain_cmpt = 1'b0;
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_skip();
    test_gain_change();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
